// File: rtl/r32_pkg.sv
// Shared RV32 definitions: load funct3 encodings and the pending-load record.
package r32_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } load_pending_t;

endpackage

// File: rtl/load_pending_fifo.sv
// In-order FIFO of outstanding loads; exposes every slot so the scoreboard can compare.
module load_pending_fifo
    import r32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_push,
    input  load_pending_t                   i_push_data,
    input  logic                            i_pop,
    output load_pending_t                   o_head,
    output logic [$clog2(DEPTH):0]          o_count,
    output logic                            o_full,
    output logic                            o_empty,
    output load_pending_t [DEPTH-1:0]       o_entries,
    output logic [DEPTH-1:0]                o_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    load_pending_t [DEPTH-1:0] entries_r;
    logic [DEPTH-1:0]          valid_r;
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic                      push_ok_s;
    logic                      pop_ok_s;

    assign o_full    = (count_r == CNT_FULL);
    assign o_empty   = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = i_push && !o_full;
    assign pop_ok_s  = i_pop && !o_empty;
    assign o_head    = entries_r[rd_ptr_r];
    assign o_count   = count_r;
    assign o_entries = entries_r;
    assign o_valid   = valid_r;

    // Slot storage, valid mask, wrapping pointers and occupancy count.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            entries_r <= '0;
            valid_r   <= {DEPTH{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            // Push and pop never target the same slot: that needs empty-or-full.
            if (push_ok_s) begin
                entries_r[wr_ptr_r] <= i_push_data;
                valid_r[wr_ptr_r]   <= 1'b1;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: arbitrates ALU results against load responses and owns the
// register-file write port, with a pending-load scoreboard for decode stalls.
module writeback_unit
    import r32_pkg::*;
#(
    parameter int LOAD_DEPTH = 4
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_alu_valid,
    output logic                            o_alu_ready,
    input  logic [4:0]                      i_alu_rd,
    input  logic [31:0]                     i_alu_result,
    input  logic                            i_load_issue_valid,
    output logic                            o_load_issue_ready,
    input  logic [4:0]                      i_load_rd,
    input  logic [2:0]                      i_load_funct3,
    input  logic [1:0]                      i_load_addr_lo,
    input  logic                            i_mem_rvalid,
    output logic                            o_mem_rready,
    input  logic [31:0]                     i_mem_rdata,
    output logic [4:0]                      o_wb_sel,
    output logic [31:0]                     o_wb_data,
    output logic                            o_wb_enable,
    input  logic [4:0]                      i_query_rs1,
    input  logic [4:0]                      i_query_rs2,
    output logic                            o_rs1_busy,
    output logic                            o_rs2_busy,
    output logic [$clog2(LOAD_DEPTH):0]     o_pending_count
);

    load_pending_t                  head_s;
    load_pending_t                  push_data_s;
    load_pending_t [LOAD_DEPTH-1:0] entries_s;
    logic [LOAD_DEPTH-1:0]          valid_s;
    logic                           full_s;
    logic                           empty_s;
    logic                           resp_fire_s;
    logic                           alu_fire_s;
    logic                           push_s;
    logic                           rs1_busy_s;
    logic                           rs2_busy_s;
    logic [4:0]                     wb_sel_r;
    logic [31:0]                    wb_data_r;
    logic                           wb_enable_r;

    function automatic logic [31:0] extract_load(input logic [2:0] funct3,
                                                 input logic [1:0] addr_lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result_v;
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            LB:      result_v = {{24{byte_v[7]}}, byte_v};
            LBU:     result_v = {24'h000000, byte_v};
            LH:      result_v = {{16{half_v[15]}}, half_v};
            LHU:     result_v = {16'h0000, half_v};
            default: result_v = rdata;
        endcase
        return result_v;
    endfunction

    assign push_data_s = '{rd: i_load_rd, funct3: i_load_funct3, addr_lo: i_load_addr_lo};
    assign push_s      = i_load_issue_valid && !full_s;
    assign resp_fire_s = i_mem_rvalid && !empty_s;
    assign alu_fire_s  = i_alu_valid && !resp_fire_s;

    load_pending_fifo #(.DEPTH(LOAD_DEPTH)) u_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (push_s),
        .i_push_data (push_data_s),
        .i_pop       (resp_fire_s),
        .o_head      (head_s),
        .o_count     (o_pending_count),
        .o_full      (full_s),
        .o_empty     (empty_s),
        .o_entries   (entries_s),
        .o_valid     (valid_s)
    );

    // Scoreboard: a source is busy while any live entry targets it (x0 never is).
    always_comb begin
        rs1_busy_s = 1'b0;
        rs2_busy_s = 1'b0;
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            if (valid_s[i] && (entries_s[i].rd == i_query_rs1) && (i_query_rs1 != 5'd0)) begin
                rs1_busy_s = 1'b1;
            end else begin
                rs1_busy_s = rs1_busy_s;
            end
            if (valid_s[i] && (entries_s[i].rd == i_query_rs2) && (i_query_rs2 != 5'd0)) begin
                rs2_busy_s = 1'b1;
            end else begin
                rs2_busy_s = rs2_busy_s;
            end
        end
    end

    // Write port: load response wins; sel/data only move when a real write happens.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wb_enable_r <= 1'b0;
            wb_sel_r    <= 5'd0;
            wb_data_r   <= 32'h0000_0000;
        end else if (resp_fire_s) begin
            wb_enable_r <= (head_s.rd != 5'd0);
            if (head_s.rd != 5'd0) begin
                wb_sel_r  <= head_s.rd;
                wb_data_r <= extract_load(head_s.funct3, head_s.addr_lo, i_mem_rdata);
            end
        end else if (alu_fire_s) begin
            wb_enable_r <= (i_alu_rd != 5'd0);
            if (i_alu_rd != 5'd0) begin
                wb_sel_r  <= i_alu_rd;
                wb_data_r <= i_alu_result;
            end
        end else begin
            wb_enable_r <= 1'b0;
        end
    end

    assign o_wb_enable        = wb_enable_r;
    assign o_wb_sel           = wb_sel_r;
    assign o_wb_data          = wb_data_r;
    assign o_alu_ready        = !resp_fire_s;
    assign o_mem_rready       = !empty_s;
    assign o_load_issue_ready = !full_s;
    assign o_rs1_busy         = rs1_busy_s;
    assign o_rs2_busy         = rs2_busy_s;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed scenarios plus a randomized run checked against a queue-based model.
module tb_writeback_unit;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic        o_alu_ready;
    logic [4:0]  i_alu_rd = 5'd0;
    logic [31:0] i_alu_result = 32'h0;
    logic        i_load_issue_valid = 1'b0;
    logic        o_load_issue_ready;
    logic [4:0]  i_load_rd = 5'd0;
    logic [2:0]  i_load_funct3 = 3'd0;
    logic [1:0]  i_load_addr_lo = 2'd0;
    logic        i_mem_rvalid = 1'b0;
    logic        o_mem_rready;
    logic [31:0] i_mem_rdata = 32'h0;
    logic [4:0]  o_wb_sel;
    logic [31:0] o_wb_data;
    logic        o_wb_enable;
    logic [4:0]  i_query_rs1 = 5'd0;
    logic [4:0]  i_query_rs2 = 5'd0;
    logic        o_rs1_busy;
    logic        o_rs2_busy;
    logic [2:0]  o_pending_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] a;
    } ld_t;

    writeback_unit #(.LOAD_DEPTH(4)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_rd(i_alu_rd), .i_alu_result(i_alu_result),
        .i_load_issue_valid(i_load_issue_valid), .o_load_issue_ready(o_load_issue_ready),
        .i_load_rd(i_load_rd), .i_load_funct3(i_load_funct3), .i_load_addr_lo(i_load_addr_lo),
        .i_mem_rvalid(i_mem_rvalid), .o_mem_rready(o_mem_rready), .i_mem_rdata(i_mem_rdata),
        .o_wb_sel(o_wb_sel), .o_wb_data(o_wb_data), .o_wb_enable(o_wb_enable),
        .i_query_rs1(i_query_rs1), .i_query_rs2(i_query_rs2),
        .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
        .o_pending_count(o_pending_count)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'h0000_00FF;
        h = (d >> (16 * (a / 2))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    task automatic test_reset();
        #1;
        checks++; if (o_wb_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", o_wb_enable); end
        checks++; if (o_wb_sel !== 5'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", o_wb_sel); end
        checks++; if (o_wb_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", o_wb_data); end
        checks++; if (o_pending_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_pending_count); end
        checks++; if (o_mem_rready !== 1'b0 || o_load_issue_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got rready=%b issue=%b want 0/1", o_mem_rready, o_load_issue_ready); end
        checks++; if (o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b%b want 00", o_rs1_busy, o_rs2_busy); end
    endtask

    task automatic test_alu();
        @(negedge i_clock);
        i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_result = 32'hDEAD_BEEF;
        #1;
        checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", o_alu_ready); end
        @(posedge i_clock); #1;
        checks++; if (o_wb_enable !== 1'b1 || o_wb_sel !== 5'd5 || o_wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_write got en=%b sel=%0d data=%h want 1/5/deadbeef", o_wb_enable, o_wb_sel, o_wb_data); end
        @(negedge i_clock);
        i_alu_rd = 5'd0; i_alu_result = 32'h1234_5678;
        #1;
        checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL alu_x0_ready got %b want 1", o_alu_ready); end
        @(posedge i_clock); #1;
        checks++; if (o_wb_enable !== 1'b0 || o_wb_sel !== 5'd5 || o_wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_x0_hold got en=%b sel=%0d data=%h want 0/5/deadbeef", o_wb_enable, o_wb_sel, o_wb_data); end
        @(negedge i_clock);
        i_alu_valid = 1'b0;
        @(posedge i_clock); #1;
        checks++; if (o_wb_enable !== 1'b0) begin errors++; $display("FAIL alu_idle_en got %b want 0", o_wb_enable); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_t [8]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd1, 3'd0, 3'd3, 3'd4};
        logic [1:0]  a_t  [8]  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1};
        logic [31:0] d_t  [8]  = '{32'h0080FF11, 32'h0080FF11, 32'h0080FF11, 32'h80011234,
                                   32'hABCD0000, 32'h7F000000, 32'h12345678, 32'h0000C300};
        logic [31:0] e_t  [8]  = '{32'hFFFFFF80, 32'h00000080, 32'h00000080, 32'h00008001,
                                   32'hFFFFABCD, 32'h0000007F, 32'h12345678, 32'h000000C3};
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clock);
            i_load_issue_valid = 1'b1; i_load_rd = 5'd3; i_load_funct3 = f3_t[k]; i_load_addr_lo = a_t[k];
            @(negedge i_clock);
            i_load_issue_valid = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = d_t[k];
            @(posedge i_clock); #1;
            checks++; if (o_wb_enable !== 1'b1 || o_wb_sel !== 5'd3 || o_wb_data !== e_t[k]) begin
                errors++; $display("FAIL load_ext[%0d] got en=%b sel=%0d data=%h want 1/3/%h", k, o_wb_enable, o_wb_sel, o_wb_data, e_t[k]); end
            @(negedge i_clock);
            i_mem_rvalid = 1'b0;
        end
    endtask

    task automatic test_conflict();
        @(negedge i_clock);
        i_load_issue_valid = 1'b1; i_load_rd = 5'd9; i_load_funct3 = 3'd2; i_load_addr_lo = 2'd0;
        @(negedge i_clock);
        i_load_issue_valid = 1'b0;
        i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_result = 32'hAAAA_0007;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBBBB_0009;
        #1;
        checks++; if (o_alu_ready !== 1'b0) begin errors++; $display("FAIL conflict_stall got %b want 0", o_alu_ready); end
        @(posedge i_clock); #1;
        checks++; if (o_wb_enable !== 1'b1 || o_wb_sel !== 5'd9 || o_wb_data !== 32'hBBBB_0009) begin
            errors++; $display("FAIL conflict_load_first got en=%b sel=%0d data=%h want 1/9/bbbb0009", o_wb_enable, o_wb_sel, o_wb_data); end
        @(negedge i_clock);
        i_mem_rvalid = 1'b0;
        #1;
        checks++; if (o_alu_ready !== 1'b1) begin errors++; $display("FAIL conflict_release got %b want 1", o_alu_ready); end
        @(posedge i_clock); #1;
        checks++; if (o_wb_enable !== 1'b1 || o_wb_sel !== 5'd7 || o_wb_data !== 32'hAAAA_0007) begin
            errors++; $display("FAIL conflict_alu_second got en=%b sel=%0d data=%h want 1/7/aaaa0007", o_wb_enable, o_wb_sel, o_wb_data); end
        @(negedge i_clock);
        i_alu_valid = 1'b0;
    endtask

    task automatic test_full();
        logic [4:0] drain_t [3] = '{5'd12, 5'd13, 5'd15};
        i_load_funct3 = 3'd2; i_load_addr_lo = 2'd0; i_mem_rdata = 32'h5555_0000;
        for (int k = 0; k < 5; k++) begin
            i_load_issue_valid = 1'b1; i_load_rd = 5'(10 + k);
            #1;
            if (k == 4) begin
                checks++; if (o_load_issue_ready !== 1'b0 || o_pending_count !== 3'd4) begin
                    errors++; $display("FAIL full_flag got ready=%b count=%0d want 0/4", o_load_issue_ready, o_pending_count); end
            end
            @(negedge i_clock);
        end
        i_load_issue_valid = 1'b0;
        #1;
        checks++; if (o_pending_count !== 3'd4) begin errors++; $display("FAIL full_drop got count=%0d want 4", o_pending_count); end
        i_mem_rvalid = 1'b1;
        @(posedge i_clock); #1;
        checks++; if (o_wb_sel !== 5'd10 || o_pending_count !== 3'd3) begin
            errors++; $display("FAIL full_pop got sel=%0d count=%0d want 10/3", o_wb_sel, o_pending_count); end
        @(negedge i_clock);
        i_load_issue_valid = 1'b1; i_load_rd = 5'd15;
        #1;
        checks++; if (o_load_issue_ready !== 1'b1) begin errors++; $display("FAIL full_ready3 got %b want 1", o_load_issue_ready); end
        @(posedge i_clock); #1;
        checks++; if (o_wb_sel !== 5'd11 || o_pending_count !== 3'd3) begin
            errors++; $display("FAIL full_pushpop got sel=%0d count=%0d want 11/3", o_wb_sel, o_pending_count); end
        @(negedge i_clock);
        i_load_issue_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clock); #1;
            checks++; if (o_wb_enable !== 1'b1 || o_wb_sel !== drain_t[k]) begin
                errors++; $display("FAIL full_drain[%0d] got en=%b sel=%0d want 1/%0d", k, o_wb_enable, o_wb_sel, drain_t[k]); end
        end
        @(negedge i_clock);
        i_mem_rvalid = 1'b0;
        #1;
        checks++; if (o_pending_count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d want 0", o_pending_count); end
    endtask

    task automatic test_scoreboard();
        logic [4:0] rd_t [3] = '{5'd4, 5'd0, 5'd4};
        logic       en_t [3] = '{1'b1, 1'b0, 1'b1};
        logic       b_t  [3] = '{1'b1, 1'b1, 1'b0};
        i_query_rs1 = 5'd4; i_query_rs2 = 5'd0; i_load_funct3 = 3'd4; i_load_addr_lo = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clock);
            i_load_issue_valid = 1'b1; i_load_rd = rd_t[k];
        end
        @(negedge i_clock);
        i_load_issue_valid = 1'b0;
        #1;
        checks++; if (o_rs1_busy !== 1'b1 || o_rs2_busy !== 1'b0 || o_pending_count !== 3'd3) begin
            errors++; $display("FAIL sb_pending got b1=%b b2=%b count=%0d want 1/0/3", o_rs1_busy, o_rs2_busy, o_pending_count); end
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_00FF;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clock); #1;
            checks++; if (o_wb_enable !== en_t[k] || o_rs1_busy !== b_t[k] || o_rs2_busy !== 1'b0) begin
                errors++; $display("FAIL sb_retire[%0d] got en=%b b1=%b b2=%b want %b/%b/0", k, o_wb_enable, o_rs1_busy, o_rs2_busy, en_t[k], b_t[k]); end
        end
        checks++; if (o_wb_sel !== 5'd4 || o_wb_data !== 32'h0000_00FF) begin
            errors++; $display("FAIL sb_data got sel=%0d data=%h want 4/000000ff", o_wb_sel, o_wb_data); end
        @(negedge i_clock);
        i_mem_rvalid = 1'b0;
    endtask

    task automatic test_mid_reset();
        i_query_rs1 = 5'd8; i_load_funct3 = 3'd2;
        i_load_issue_valid = 1'b1; i_load_rd = 5'd6;
        @(negedge i_clock);
        i_load_rd = 5'd8;
        @(negedge i_clock);
        i_load_issue_valid = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BAD_F00D;
        @(posedge i_clock); #1;
        checks++; if (o_wb_enable !== 1'b1 || o_rs1_busy !== 1'b1) begin
            errors++; $display("FAIL mrst_pre got en=%b b1=%b want 1/1", o_wb_enable, o_rs1_busy); end
        #2; i_reset = 1'b1; #1;
        checks++; if (o_wb_enable !== 1'b0 || o_pending_count !== 3'd0 || o_rs1_busy !== 1'b0) begin
            errors++; $display("FAIL mrst_async got en=%b count=%0d b1=%b want 0/0/0", o_wb_enable, o_pending_count, o_rs1_busy); end
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        checks++; if (o_mem_rready !== 1'b0) begin errors++; $display("FAIL mrst_rready got %b want 0", o_mem_rready); end
        @(posedge i_clock); #1;
        checks++; if (o_wb_enable !== 1'b0 || o_wb_sel !== 5'd0) begin
            errors++; $display("FAIL mrst_nowrite got en=%b sel=%0d want 0/0", o_wb_enable, o_wb_sel); end
        @(negedge i_clock);
        i_mem_rvalid = 1'b0;
    endtask

    task automatic test_random();
        ld_t         pend_q[$];
        ld_t         h;
        logic        exp_en = 1'b0;
        logic [4:0]  exp_sel = 5'd0;
        logic [31:0] exp_data = 32'h0;
        logic        alu_hold = 1'b0;
        logic        b1, b2, fire_resp, fire_alu, do_push;
        int          sz;
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!alu_hold) begin
                i_alu_valid = 1'($urandom_range(0, 1)); i_alu_rd = 5'($urandom_range(0, 7)); i_alu_result = $urandom;
            end
            i_load_issue_valid = ($urandom_range(0, 9) < 5);
            i_load_rd = 5'($urandom_range(0, 7)); i_load_funct3 = 3'($urandom_range(0, 7));
            i_load_addr_lo = 2'($urandom_range(0, 3));
            i_mem_rvalid = ($urandom_range(0, 9) < 4); i_mem_rdata = $urandom;
            i_query_rs1 = 5'($urandom_range(0, 7)); i_query_rs2 = 5'($urandom_range(0, 7));
            #1;
            sz = pend_q.size();
            b1 = 1'b0; b2 = 1'b0;
            foreach (pend_q[j]) begin
                if (i_query_rs1 != 5'd0 && pend_q[j].rd == i_query_rs1) b1 = 1'b1;
                if (i_query_rs2 != 5'd0 && pend_q[j].rd == i_query_rs2) b2 = 1'b1;
            end
            checks++; if (o_pending_count !== sz[2:0]) begin errors++; $display("FAIL rnd_count@%0d got %0d want %0d", cyc, o_pending_count, sz); end
            checks++; if (o_mem_rready !== (sz != 0)) begin errors++; $display("FAIL rnd_rready@%0d got %b want %b", cyc, o_mem_rready, sz != 0); end
            checks++; if (o_load_issue_ready !== (sz < 4)) begin errors++; $display("FAIL rnd_issue@%0d got %b want %b", cyc, o_load_issue_ready, sz < 4); end
            checks++; if (o_alu_ready !== !(i_mem_rvalid && sz != 0)) begin errors++; $display("FAIL rnd_alu_ready@%0d got %b", cyc, o_alu_ready); end
            checks++; if (o_rs1_busy !== b1 || o_rs2_busy !== b2) begin
                errors++; $display("FAIL rnd_busy@%0d got %b%b want %b%b", cyc, o_rs1_busy, o_rs2_busy, b1, b2); end
            fire_resp = i_mem_rvalid && (sz != 0);
            fire_alu  = i_alu_valid && !fire_resp;
            do_push   = i_load_issue_valid && (sz < 4);
            if (fire_resp) begin
                h = pend_q.pop_front();
                exp_en = (h.rd != 5'd0);
                if (exp_en) begin exp_sel = h.rd; exp_data = ref_extract(h.f3, h.a, i_mem_rdata); end
            end else if (fire_alu) begin
                exp_en = (i_alu_rd != 5'd0);
                if (exp_en) begin exp_sel = i_alu_rd; exp_data = i_alu_result; end
            end else begin
                exp_en = 1'b0;
            end
            if (do_push) pend_q.push_back('{rd: i_load_rd, f3: i_load_funct3, a: i_load_addr_lo});
            alu_hold = i_alu_valid && !fire_alu;
            @(posedge i_clock); #1;
            checks++; if (o_wb_enable !== exp_en || o_wb_sel !== exp_sel || o_wb_data !== exp_data) begin
                errors++; $display("FAIL rnd_wb@%0d got en=%b sel=%0d data=%h want %b/%0d/%h",
                                   cyc, o_wb_enable, o_wb_sel, o_wb_data, exp_en, exp_sel, exp_data); end
            @(negedge i_clock);
        end
        i_alu_valid = 1'b0; i_load_issue_valid = 1'b0; i_mem_rvalid = 1'b0;
    endtask

    initial begin
        #12;
        @(negedge i_clock);
        i_reset = 1'b0;
        test_reset();
        test_alu();
        test_load_ext();
        test_conflict();
        @(negedge i_clock);
        test_full();
        test_scoreboard();
        @(negedge i_clock);
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage; sole driver of the register file write port (select, data, enable).
- Merges single-cycle ALU results with in-order memory load responses.
- Performs load byte/half extraction and sign/zero extension.
- Keeps a pending-load scoreboard so decode can stall on registers awaiting load data.

Parameters:
- LOAD_DEPTH, 4, max outstanding loads; power of two, ≥2.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_alu_valid  in  1  ALU result present
- o_alu_ready  out  1  ALU result accepted this cycle
- i_alu_rd  in  5  ALU destination register
- i_alu_result  in  32  ALU result
- i_load_issue_valid  in  1  load issued to memory this cycle
- o_load_issue_ready  out  1  pending FIFO can take an entry
- i_load_rd  in  5  load destination register
- i_load_funct3  in  3  load type (LB/LH/LW/LBU/LHU encoding)
- i_load_addr_lo  in  2  address bits [1:0]
- i_mem_rvalid  in  1  memory read data valid
- o_mem_rready  out  1  response accepted
- i_mem_rdata  in  32  aligned memory word
- o_wb_sel  out  5  register file write select
- o_wb_data  out  32  register file write data
- o_wb_enable  out  1  register file write enable
- i_query_rs1, i_query_rs2  in  5 each  decode source registers
- o_rs1_busy, o_rs2_busy  out  1 each  source has a pending load
- o_pending_count  out  $clog2(LOAD_DEPTH)+1  outstanding loads

Behaviour:
- Reset: FIFO empty; o_wb_sel=0, o_wb_data=0, o_wb_enable=0; o_pending_count=0; busy outputs 0.
- Pending FIFO:
  - Stores {rd, funct3, addr_lo} in issue order.
  - o_load_issue_ready = (count < LOAD_DEPTH).
  - Push on i_load_issue_valid && o_load_issue_ready.
  - Pop on response handshake. Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo LOAD_DEPTH.
  - Issue while full is not accepted and is not recorded.
- Response path:
  - o_mem_rready = FIFO non-empty.
  - i_mem_rvalid with FIFO empty is ignored; no write occurs.
  - Memory responses arrive in issue order.
- Arbitration: a load response handshake has priority.
  - o_alu_ready = !(i_mem_rvalid && FIFO non-empty).
  - A stalled ALU result must hold its values until accepted.
- Extraction (from the head entry):
  - LB / LBU: byte = rdata[8*addr_lo +: 8], sign- or zero-extended.
  - LH / LHU: half = rdata[16*addr_lo[1] +: 16], sign- or zero-extended.
  - LW and unsupported funct3: full word.
  - addr_lo[0] is ignored for halfwords; misalignment is checked upstream.
- Write port:
  - Registered, latency 1: an accepted source in cycle N appears on o_wb_* in cycle N+1 for exactly one cycle.
  - o_wb_enable=0 when rd==0, though the result/response is still consumed.
  - o_wb_sel and o_wb_data hold their last value when the enable is low.
- Scoreboard:
  - o_rsX_busy combinational: 1 if any valid FIFO entry has rd == i_query_rsX and rd != 0.
  - An entry popped in cycle N stops reporting busy in cycle N+1, which is the same cycle its data is written.
  - Decode must therefore stall one further cycle or forward from o_wb_*.
- Hazards:
  - No WAW checking; decode guarantees program order by stalling on busy.
  - Two pending loads to the same rd keep busy until both retire.
- Reset mid-operation: FIFO is flushed and any in-flight write is dropped (enable forced 0 asynchronously). Responses after reset with an empty FIFO are ignored.

Decomposition:
- Shared package r32_pkg:
  - Load funct3 localparams: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Typedef struct load_pending_t {rd[4:0], funct3[2:0], addr_lo[1:0]}.
- Sub-module load_pending_fifo:
  - Parameterised depth, push/pop, count.
  - Exposes the entry array and valid mask for the scoreboard compare.
- Extraction stays inline as a combinational function.

Test Plan:
- ALU only: valid, rd=5, result=0xDEADBEEF -> next cycle wb_enable=1, sel=5, data=0xDEADBEEF; rd=0 -> wb_enable=0 and alu_ready=1.
- Load extension: issue LB rd=3 addr_lo=2, rdata=0x0080FF11 -> data=0xFFFFFF80; LBU same -> 0x00000080; LH addr_lo=2 -> 0x00000080; LHU rdata=0x8001xxxx addr_lo=2 -> 0x00008001.
- Conflict: ALU valid rd=7 and response valid for rd=9 in the same cycle -> alu_ready=0, rd=9 written first, rd=7 written the cycle after.
- Full FIFO: issue 4 loads -> issue_ready=0 and pending_count=4; 5th issue dropped; simultaneous response and issue at count=3 -> count stays 3.
- Scoreboard: pending loads to rd=4 twice; query rs1=4 -> busy until second response popped; query rs2=0 -> never busy.
- Reset: with 2 loads pending, assert i_reset mid-cycle -> wb_enable=0 immediately and count=0; subsequent rvalid -> rready=0 and no write.
